// File: rtl/prf_free_list_if.sv
// Rename/retire/recovery bundle for the physical register free list.
// master drives allocate, retire and flush requests; slave is the free list.
interface prf_free_list_if #(
  parameter int PRF_IDX = 6
);
  logic               alloc_1;
  logic               alloc_2;
  logic               retire_valid_1;
  logic [PRF_IDX-1:0] retire_old_1;
  logic               retire_valid_2;
  logic [PRF_IDX-1:0] retire_old_2;
  logic               flush;
  logic [PRF_IDX-1:0] free_reg_1;
  logic [PRF_IDX-1:0] free_reg_2;
  logic               free_valid_1;
  logic               free_valid_2;
  logic [PRF_IDX:0]   free_count;
  logic               fl_error;

  modport master (
    output alloc_1, alloc_2, retire_valid_1, retire_old_1,
           retire_valid_2, retire_old_2, flush,
    input  free_reg_1, free_reg_2, free_valid_1, free_valid_2,
           free_count, fl_error
  );

  modport slave (
    input  alloc_1, alloc_2, retire_valid_1, retire_old_1,
           retire_valid_2, retire_old_2, flush,
    output free_reg_1, free_reg_2, free_valid_1, free_valid_2,
           free_count, fl_error
  );
endinterface

// File: rtl/prf_free_list.sv
// Circular free list of physical registers: two allocs from head, two retire pushes at tail,
// flush rewinds head to arch_head. Define FREELIST_ERR_EN for the sticky fl_error misuse flag.
module prf_free_list #(
  parameter int PRF_SIZE = 64,
  parameter int ARF_SIZE = 32,
  parameter int PRF_IDX  = 6
) (
  input  logic           clock,
  input  logic           reset,
  prf_free_list_if.slave fl
);
  localparam int DEPTH = PRF_SIZE - ARF_SIZE;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PRF_IDX + 1;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [PRF_IDX-1:0] reg_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) return '0;
    else return p + ptr_t'(1);
  endfunction

  reg_t buf_q [DEPTH];
  reg_t buf_d [DEPTH];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t arch_head_q, arch_head_d;
  cnt_t count_q, count_d;

  cnt_t n_alloc;
  cnt_t n_push;
  logic alloc_ok;
  logic push1_ok;
  logic push2_ok;

  always_comb begin
    buf_d       = buf_q;
    head_d      = head_q;
    tail_d      = tail_q;
    arch_head_d = arch_head_q;
    count_d     = count_q;

    n_alloc  = cnt_t'(fl.alloc_1) + cnt_t'(fl.alloc_2);
    alloc_ok = (n_alloc <= count_q);
    // A push into a list that already holds every entry is dropped.
    push1_ok = fl.retire_valid_1 && (count_q != cnt_t'(DEPTH));
    push2_ok = fl.retire_valid_2 && ((count_q + cnt_t'(push1_ok)) != cnt_t'(DEPTH));
    n_push   = cnt_t'(push1_ok) + cnt_t'(push2_ok);

    if (push1_ok) begin
      buf_d[tail_d] = fl.retire_old_1;
      tail_d        = ptr_inc(tail_d);
    end
    if (push2_ok) begin
      buf_d[tail_d] = fl.retire_old_2;
      tail_d        = ptr_inc(tail_d);
    end
    if (fl.retire_valid_1) arch_head_d = ptr_inc(arch_head_d);
    if (fl.retire_valid_2) arch_head_d = ptr_inc(arch_head_d);

    if (fl.flush) begin
      head_d = arch_head_d;
      // tail == arch_head after recovery means nothing speculative is outstanding: full list.
      if (tail_d == arch_head_d)
        count_d = cnt_t'(DEPTH);
      else if (tail_d > arch_head_d)
        count_d = cnt_t'(tail_d) - cnt_t'(arch_head_d);
      else
        count_d = cnt_t'(DEPTH) - cnt_t'(arch_head_d) + cnt_t'(tail_d);
    end else begin
      if (alloc_ok && (n_alloc != '0)) head_d = ptr_inc(head_d);
      if (alloc_ok && (n_alloc == cnt_t'(2))) head_d = ptr_inc(head_d);
      count_d = count_q + n_push - (alloc_ok ? n_alloc : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= reg_t'(ARF_SIZE + i);
      head_q      <= '0;
      tail_q      <= '0;
      arch_head_q <= '0;
      count_q     <= cnt_t'(DEPTH);
    end else begin
      buf_q       <= buf_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      arch_head_q <= arch_head_d;
      count_q     <= count_d;
    end
  end

  assign fl.free_reg_1   = buf_q[head_q];
  assign fl.free_reg_2   = buf_q[ptr_inc(head_q)];
  assign fl.free_valid_1 = (count_q != '0);
  assign fl.free_valid_2 = (count_q >= cnt_t'(2));
  assign fl.free_count   = count_q;

`ifdef FREELIST_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (!fl.flush && !alloc_ok)
          | (fl.retire_valid_1 && !push1_ok)
          | (fl.retire_valid_2 && !push2_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign fl.fl_error = err_q;
`else
  assign fl.fl_error = 1'b0;
`endif
endmodule
